// File: rtl/mulu_seq.sv
// Sequential unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one multiplier bit per clock.
// Define MULU_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module mulu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_multiplicand,
    input  logic [WIDTH-1:0]   i_multiplier,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [2*WIDTH-1:0] o_product,
    output logic               o_busy
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 valid_q, valid_d;
    logic [2*WIDTH-1:0]   acc_step;

    // Accumulator after this iteration's conditional add; cannot overflow 2*WIDTH bits.
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        product_d = product_q;
        valid_d   = valid_q;
        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    mcand_d  = {{WIDTH{1'b0}}, i_multiplicand};
                    mplier_d = i_multiplier;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
`ifdef MULU_EARLY_TERM_EN
                if (mplier_q == '0) begin
                    product_d = acc_q;
                    valid_d   = 1'b1;
                    state_d   = StDone;
                end else begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + CW'(1);
                end
`else
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    product_d = acc_step;
                    valid_d   = 1'b1;
                    state_d   = StDone;
                end
`endif
            end
            StDone: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            product_q <= product_d;
            valid_q   <= valid_d;
        end
    end

    assign o_ready   = (state_q == StIdle);
    assign o_busy    = (state_q == StCalc);
    assign o_valid   = valid_q;
    assign o_product = product_q;

endmodule

// File: tb/tb_mulu_seq.sv
// Self-checking bench for mulu_seq: directed corner cases, backpressure, mid-op reset and
// randomized back-to-back traffic scored against plain 64-bit multiplication.
module tb_mulu_seq;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NRAND = 1000;

    logic               i_clk;
    logic               i_rst_n;
    logic               i_valid;
    logic               o_ready;
    logic [WIDTH-1:0]   i_multiplicand;
    logic [WIDTH-1:0]   i_multiplier;
    logic               o_valid;
    logic               i_ready;
    logic [2*WIDTH-1:0] o_product;
    logic               o_busy;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q[$];
    int          rx_cnt;

    mulu_seq #(.WIDTH(WIDTH)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_multiplicand (i_multiplicand),
        .i_multiplier   (i_multiplier),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_product      (o_product),
        .o_busy         (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Clocks from accept edge to the edge raising o_valid.
    function automatic int exp_lat(input logic [31:0] b);
`ifdef MULU_EARLY_TERM_EN
        int msb;
        msb = -1;
        for (int i = 0; i < 32; i++) if (b[i]) msb = i;
        return (msb < 0) ? 1 : msb + 2;
`else
        return WIDTH;
`endif
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        int          cyc;
        logic [63:0] expv;
        expv = 64'(a) * 64'(b);
        check("op_ready_idle", 64'(o_ready), 64'd1);
        i_multiplicand = a;
        i_multiplier   = b;
        i_valid        = 1'b1;
        i_ready        = 1'b1;
        tick();
        i_valid        = 1'b0;
        i_multiplicand = $urandom;
        i_multiplier   = $urandom;
        cyc = 0;
        while (!o_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        check("op_latency", 64'(cyc), 64'(exp_lat(b)));
        check("op_product", o_product, expv);
        tick();
        check("op_valid_drop", 64'(o_valid), 64'd0);
        check("op_ready_back", 64'(o_ready), 64'd1);
    endtask

    initial begin
        int          cyc;
        i_rst_n        = 1'b0;
        i_valid        = 1'b0;
        i_ready        = 1'b0;
        i_multiplicand = '0;
        i_multiplier   = '0;
        repeat (3) tick();
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_product", o_product, 64'd0);
        i_rst_n = 1'b1;
        tick();

        run_op(32'd7, 32'd6);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(32'd0, 32'h1234_5678);
        run_op(32'h8000_0000, 32'd2);
        run_op(32'h1234_5678, 32'd0);
        run_op(32'd9, 32'd5);
        run_op(32'd1, 32'h8000_0000);

        // Backpressure: result held while consumer stalls and inputs churn.
        i_multiplicand = 32'h1234;
        i_multiplier   = 32'h10;
        i_valid        = 1'b1;
        i_ready        = 1'b0;
        tick();
        i_valid = 1'b0;
        check("bp_busy", 64'(o_busy), 64'd1);
        cyc = 0;
        while (!o_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        check("bp_latency", 64'(cyc), 64'(exp_lat(32'h10)));
        for (int i = 0; i < 10; i++) begin
            i_valid        = 1'($urandom);
            i_multiplicand = $urandom;
            i_multiplier   = $urandom;
            tick();
            check("bp_valid_hold", 64'(o_valid), 64'd1);
            check("bp_product_hold", o_product, 64'h12340);
            check("bp_ready_low", 64'(o_ready), 64'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        check("bp_release_valid", 64'(o_valid), 64'd0);
        check("bp_release_ready", 64'(o_ready), 64'd1);
        check("bp_product_keep", o_product, 64'h12340);

        // Asynchronous reset in the middle of a calculation.
        i_multiplicand = 32'hDEAD_BEEF;
        i_multiplier   = 32'hFFFF_FFFF;
        i_valid        = 1'b1;
        tick();
        i_valid = 1'b0;
        repeat (15) tick();
        check("mid_busy", 64'(o_busy), 64'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_ready", 64'(o_ready), 64'd1);
        check("arst_valid", 64'(o_valid), 64'd0);
        check("arst_busy", 64'(o_busy), 64'd0);
        check("arst_product", o_product, 64'd0);
        repeat (2) tick();
        i_rst_n = 1'b1;
        tick();
        check("arst_no_result", 64'(o_valid), 64'd0);
        run_op(32'd3, 32'd5);

        // Randomized back-to-back traffic with random gaps on both sides.
        rx_cnt = 0;
        fork
            begin : drv
                for (int n = 0; n < int'(NRAND); n++) begin
                    int gap;
                    int tries;
                    logic [31:0] a, b;
                    gap = int'($urandom_range(0, 3));
                    repeat (gap) tick();
                    a = $urandom;
                    b = $urandom;
                    if ($urandom_range(0, 9) == 0) a = '0;
                    if ($urandom_range(0, 9) == 0) b = '0;
                    if ($urandom_range(0, 9) == 0) b = 32'hFFFF_FFFF;
                    i_multiplicand = a;
                    i_multiplier   = b;
                    i_valid        = 1'b1;
                    tries = 0;
                    while (!o_ready && tries < 200) begin
                        tick();
                        tries++;
                    end
                    if (tries >= 200) begin
                        check("rand_accept_timeout", 64'(tries), 64'd0);
                        break;
                    end
                    exp_q.push_back(64'(a) * 64'(b));
                    tick();
                    i_valid = 1'b0;
                end
                i_valid = 1'b0;
            end
            begin : mon
                int budget;
                budget = 0;
                while (rx_cnt < int'(NRAND) && budget < 60000) begin
                    i_ready = 1'($urandom);
                    if (o_valid && i_ready) begin
                        if (exp_q.size() == 0) begin
                            check("rand_unexpected_result", o_product, 64'd0);
                        end else begin
                            check("rand_product", o_product, exp_q.pop_front());
                        end
                        rx_cnt++;
                    end
                    tick();
                    budget++;
                end
                i_ready = 1'b0;
            end
        join
        check("rand_result_count", 64'(rx_cnt), 64'(NRAND));
        check("rand_leftover", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mulu_seq.md
Name: mulu_seq

Overview:
- Sequential unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
- Companion (inverse operation) to the unsigned restoring divider datapath; processes one multiplier bit per clock.
- Valid/ready handshake on both operand input and product output; sits alongside the divider in the arithmetic unit.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH; legal range 2..64.

Ports:
- i_clk  input  1  clock, all state updates on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  operands present on i_multiplicand/i_multiplier
- o_ready  output  1  block can accept operands (high only in IDLE)
- i_multiplicand  input  WIDTH  unsigned multiplicand
- i_multiplier  input  WIDTH  unsigned multiplier
- o_valid  output  1  o_product holds final result
- i_ready  input  1  consumer accepts product
- o_product  output  2*WIDTH  unsigned product
- o_busy  output  1  high in CALC

Behaviour:
- Reset (i_rst_n low, async, any state incl. mid-CALC): state IDLE, o_ready=1, o_valid=0, o_busy=0, o_product=0, internal acc/mcand/mplier/count=0. Operation in flight is discarded; no output produced.
- States: IDLE, CALC, DONE.
- IDLE: o_ready=1. On edge with i_valid&&o_ready: mcand<={WIDTH'b0,i_multiplicand}, mplier<=i_multiplier, acc<=0, count<=0, -> CALC. Operands sampled only on that edge; later changes ignored.
- CALC, each edge: if mplier[0] then acc<=acc+mcand (2*WIDTH-bit add, no overflow possible); mcand<=mcand<<1; mplier<=mplier>>1; count<=count+1. After iteration with count==WIDTH-1: -> DONE, o_product<=final acc (including that iteration's add), o_valid<=1.
- Latency (base build): exactly WIDTH clocks from accept edge to the edge that raises o_valid (32 for default).
- DONE: o_valid=1, o_product stable, o_ready=0. On edge with i_ready: o_valid<=0, -> IDLE. o_product keeps last value until next result is written. i_valid in DONE ignored; no accept in the same cycle as output handshake (next accept earliest one cycle after return to IDLE).
- i_ready outside DONE has no effect. o_busy = (state==CALC).
- Count register width: $clog2(WIDTH)+1.
- Result: o_product == i_multiplicand * i_multiplier exactly, for all inputs.

Optional Feature:
- Macro: MULU_EARLY_TERM_EN.
- Defined: in CALC, if mplier==0 at an edge, no add, -> DONE, o_product<=acc, o_valid<=1 (this check precedes the iteration). Latency = (index of highest set multiplier bit + 1) + 1 clocks; multiplier 0 -> 1 clock; never exceeds WIDTH+1. Product value unchanged.
- Undefined: fixed WIDTH-clock latency regardless of operand values; no zero check logic.

Test Plan:
- Reset then accept 7 x 6, i_ready=1 -> o_valid rises exactly 32 clocks after accept edge, o_product=42, o_valid drops next edge, o_ready=1 following cycle.
- 0xFFFFFFFF x 0xFFFFFFFF -> o_product=0xFFFFFFFE00000001; 0 x 0x12345678 -> 0; 0x80000000 x 2 -> 0x100000000.
- Backpressure: result 0x1234 x 0x10, hold i_ready=0 for 10 cycles while toggling i_valid/operands -> o_valid stays 1, o_product=0x12340 stable, o_ready=0, no new accept; release i_ready -> IDLE.
- Assert i_rst_n=0 asynchronously at count 15 of CALC -> outputs immediately at reset values; after release, new op 3 x 5 -> 15 with full latency.
- With MULU_EARLY_TERM_EN: multiplier 0 -> o_valid 1 clock after accept, product 0; multiplier 0x5 -> 4 clocks; multiplier 0x80000000 -> 33 clocks; products correct.
- Random 1000 back-to-back operand pairs with random i_valid/i_ready gaps -> every product matches 64-bit reference, no lost or duplicated results.
